// File: rtl/spi_arbiter_if.sv
// Signal bundle between spi_arbiter and its requesters / shared SPI master.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface spi_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int SPI_WORD_LEN = 16
);

  // Requester side
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*SPI_WORD_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]              gnt;

  // Response side
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [SPI_WORD_LEN-1:0]         rsp_data;
  logic                            rsp_err;

  // Shared SPI master side
  logic                            spi_process_next_word;
  logic [SPI_WORD_LEN-1:0]         spi_data_word_send;
  logic                            spi_processing_word;
  logic [SPI_WORD_LEN-1:0]         spi_data_word_recv;

  // Status
  logic [NUM_REQ-1:0]              cs_sel;
  logic                            busy;

  modport master (
    input  req, req_data, spi_processing_word, spi_data_word_recv,
    output gnt, rsp_valid, rsp_data, rsp_err,
           spi_process_next_word, spi_data_word_send, cs_sel, busy
  );

  modport slave (
    output req, req_data, spi_processing_word, spi_data_word_recv,
    input  gnt, rsp_valid, rsp_data, rsp_err,
           spi_process_next_word, spi_data_word_send, cs_sel, busy
  );

endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// One transaction at a time: grant in IDLE, launch the word, wait for the
// master to go busy (bounded by START_TIMEOUT), wait for it to finish,
// return the received word to the owner, then idle GAP_CYCLES cycles.
module spi_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SPI_WORD_LEN  = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic          master_clock,
  input  logic          i_rst_n,
  spi_arbiter_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LAUNCH     = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;
  localparam logic [2:0] S_GAP        = 3'd5;

  localparam int         PTR_W      = $clog2(NUM_REQ);
  // Counters are sized for the largest legal parameter values (255 / 15).
  localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [2:0]              state_q,     state_d;
  logic [PTR_W-1:0]        ptr_q,       ptr_d;
  logic [NUM_REQ-1:0]      gnt_q,       gnt_d;
  logic [NUM_REQ-1:0]      cs_sel_q,    cs_sel_d;
  logic [SPI_WORD_LEN-1:0] send_q,      send_d;
  logic [SPI_WORD_LEN-1:0] rsp_data_q,  rsp_data_d;
  logic                    err_q,       err_d;
  logic [7:0]              start_cnt_q, start_cnt_d;
  logic [3:0]              gap_cnt_q,   gap_cnt_d;

  logic                    pick_valid;
  logic [PTR_W-1:0]        pick_idx;
  logic [SPI_WORD_LEN-1:0] pick_data;

  // Pick the first active requester at or after ptr, wrapping around.
  // Scanning offsets from the far end down lets the nearest one win.
  always_comb begin
    int cand;
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_data  = '0;
    cand       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == i && bus.req[i]) begin
          pick_valid = 1'b1;
          pick_idx   = PTR_W'(i);
          pick_data  = bus.req_data[i*SPI_WORD_LEN +: SPI_WORD_LEN];
        end
      end
    end
  end

  // Next-state logic for the transaction FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    cs_sel_d    = cs_sel_q;
    send_d      = send_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    start_cnt_d = start_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d[pick_idx]    = 1'b1;
          cs_sel_d           = '0;
          cs_sel_d[pick_idx] = 1'b1;
          send_d             = pick_data;
          ptr_d              = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d            = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        start_cnt_d = '0;
        state_d     = S_WAIT_START;
      end

      // Busy wins over the timeout if both happen on the last allowed cycle.
      S_WAIT_START: begin
        if (bus.spi_processing_word) begin
          state_d = S_WAIT_DONE;
        end else if (start_cnt_q == START_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          start_cnt_d = start_cnt_q + 8'd1;
        end
      end

      S_WAIT_DONE: begin
        if (!bus.spi_processing_word) state_d = S_DONE;
      end

      S_DONE: begin
        rsp_data_d = bus.spi_data_word_recv;
        cs_sel_d   = '0;
        err_d      = 1'b0;
        gap_cnt_d  = '0;
        state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d   = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge master_clock or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cs_sel_q    <= '0;
      send_q      <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      start_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cs_sel_q    <= cs_sel_d;
      send_q      <= send_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      start_cnt_q <= start_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Outputs. The response is presented during DONE itself, so the received
  // word is passed through in that cycle and held in rsp_data_q afterwards.
  assign bus.gnt                   = gnt_q;
  assign bus.cs_sel                = cs_sel_q;
  assign bus.spi_process_next_word = (state_q == S_LAUNCH);
  assign bus.spi_data_word_send    = send_q;
  assign bus.busy                  = (state_q != S_IDLE);
  assign bus.rsp_valid             = (state_q == S_DONE) ? cs_sel_q : '0;
  assign bus.rsp_err               = (state_q == S_DONE) && err_q;
  assign bus.rsp_data              = (state_q == S_DONE) ? bus.spi_data_word_recv : rsp_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with an SPI master stub and a scoreboard.
module tb_spi_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic master_clock;
  logic i_rst_n;

  spi_arbiter_if #(.NUM_REQ(N), .SPI_WORD_LEN(W)) bus ();

  spi_arbiter #(
    .NUM_REQ(N), .SPI_WORD_LEN(W), .GAP_CYCLES(2), .START_TIMEOUT(8)
  ) dut (
    .master_clock(master_clock),
    .i_rst_n     (i_rst_n),
    .bus         (bus)
  );

  initial master_clock = 1'b0;
  always #5 master_clock = ~master_clock;

  typedef struct { logic [N-1:0] gnt; logic [W-1:0] send; }           gnt_exp_t;
  typedef struct { logic [N-1:0] vld; logic [W-1:0] data; logic err; } rsp_exp_t;

  gnt_exp_t exp_gnt_q[$];
  rsp_exp_t exp_rsp_q[$];
  int       gnt_cyc_q[$];
  int       launch_cyc_q[$];
  int       rsp_cyc_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [N-1:0] cur_gnt;
  logic [W-1:0] cur_send;
  logic         prev_launch;

  // SPI master stub: 0 = fixed recv word, 1 = loopback shift, 2 = never busy
  int       stub_mode;
  int       busy_len;
  logic [W-1:0] stub_recv_word;
  logic     spi_busy;
  int       stub_cnt;
  logic [W-1:0] sreg;

  assign bus.spi_processing_word = spi_busy;
  assign bus.spi_data_word_recv  = (stub_mode == 1) ? sreg : stub_recv_word;

  always @(posedge master_clock) cyc <= cyc + 1;

  // Stub: goes busy the cycle after the launch pulse for busy_len cycles.
  // In loopback mode MOSI feeds MISO, one bit per 4 clocks (SCLK_DIV=4).
  always @(posedge master_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spi_busy <= 1'b0;
      stub_cnt <= 0;
      sreg     <= '0;
    end else if (bus.spi_process_next_word && !spi_busy) begin
      if (stub_mode != 2) begin
        spi_busy <= 1'b1;
        stub_cnt <= busy_len;
      end
      sreg <= bus.spi_data_word_send;
    end else if (spi_busy) begin
      if (stub_mode == 1 && (stub_cnt % 4) == 0) sreg <= {sreg[W-2:0], sreg[W-1]};
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt <= 1) spi_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: grants, launches and responses vs scoreboard.
  always @(negedge master_clock) begin
    if (bus.gnt != '0) begin
      gnt_cyc_q.push_back(cyc);
      check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
      if (exp_gnt_q.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 0);
      else begin
        gnt_exp_t e;
        e = exp_gnt_q.pop_front();
        check("gnt_idx", 32'(bus.gnt), 32'(e.gnt));
        cur_gnt  = e.gnt;
        cur_send = e.send;
      end
    end
    if (bus.spi_process_next_word) begin
      launch_cyc_q.push_back(cyc);
      check("launch_width", 32'(prev_launch), 0);
      check("send_word", 32'(bus.spi_data_word_send), 32'(cur_send));
      check("cs_sel_launch", 32'(bus.cs_sel), 32'(cur_gnt));
    end
    prev_launch = bus.spi_process_next_word;
    if (bus.rsp_valid != '0) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_rsp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      else begin
        rsp_exp_t r;
        r = exp_rsp_q.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(r.vld));
        check("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
      end
    end
  end

  task automatic tick();
    @(posedge master_clock);
    #1;
  endtask

  task automatic wait_gnts(input int target, input int budget);
    int n = 0;
    while (gnt_cyc_q.size() < target && n < budget) begin tick(); n++; end
    if (gnt_cyc_q.size() < target) check("timeout_gnt", 32'(gnt_cyc_q.size()), 32'(target));
  endtask

  task automatic wait_rsps(input int target, input int budget);
    int n = 0;
    while (rsp_cyc_q.size() < target && n < budget) begin tick(); n++; end
    if (rsp_cyc_q.size() < target) check("timeout_rsp", 32'(rsp_cyc_q.size()), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt), 0);
    check({tag, "_rspv"},   32'(bus.rsp_valid), 0);
    check({tag, "_rspd"},   32'(bus.rsp_data), 0);
    check({tag, "_rspe"},   32'(bus.rsp_err), 0);
    check({tag, "_launch"}, 32'(bus.spi_process_next_word), 0);
    check({tag, "_send"},   32'(bus.spi_data_word_send), 0);
    check({tag, "_cs"},     32'(bus.cs_sel), 0);
    check({tag, "_busy"},   32'(bus.busy), 0);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int order[5];
    int g0, r0, l0, sp, saved_rsp;
    logic [W-1:0] words[3];

    i_rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    stub_mode = 0;
    busy_len = 1;
    stub_recv_word = '0;
    prev_launch = 1'b0;
    cur_gnt = '0;
    cur_send = '0;

    // Reset state
    repeat (3) @(posedge master_clock);
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();

    // Contention: all four held, order 0,1,2,3,0 at >=7 cycles apart
    stub_recv_word = 16'h5A5A;
    busy_len = 1;
    bus.req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    order = '{0, 1, 2, 3, 0};
    foreach (order[k]) begin
      exp_gnt_q.push_back('{oh(order[k]), 16'(order[k] * 16'h1111)});
      exp_rsp_q.push_back('{oh(order[k]), 16'h5A5A, 1'b0});
    end
    gnt_cyc_q.delete();
    bus.req = 4'b1111;
    wait_gnts(5, 200);
    bus.req = '0;
    wait_rsps(5, 100);
    for (int k = 1; k < 5 && k < gnt_cyc_q.size(); k++) begin
      sp = gnt_cyc_q[k] - gnt_cyc_q[k-1];
      check("gnt_spacing_ge7", 32'(sp >= 7), 1);
    end

    // Pointer wrap: grant 3, then 1001 must go to 0
    g0 = gnt_cyc_q.size(); r0 = rsp_cyc_q.size();
    exp_gnt_q.push_back('{4'b1000, 16'h3333});
    exp_rsp_q.push_back('{4'b1000, 16'h5A5A, 1'b0});
    bus.req = 4'b1000;
    wait_gnts(g0 + 1, 50);
    bus.req = '0;
    wait_rsps(r0 + 1, 50);
    exp_gnt_q.push_back('{4'b0001, 16'h0000});
    exp_rsp_q.push_back('{4'b0001, 16'h5A5A, 1'b0});
    bus.req = 4'b1001;
    wait_gnts(g0 + 2, 50);
    bus.req = '0;
    wait_rsps(r0 + 2, 50);

    // Single request with a 20-cycle busy stub
    g0 = gnt_cyc_q.size(); r0 = rsp_cyc_q.size(); l0 = launch_cyc_q.size();
    busy_len = 20;
    stub_recv_word = 16'h3C5A;
    bus.req_data[31:16] = 16'hA5C3;
    exp_gnt_q.push_back('{4'b0010, 16'hA5C3});
    exp_rsp_q.push_back('{4'b0010, 16'h3C5A, 1'b0});
    bus.req = 4'b0010;
    wait_gnts(g0 + 1, 50);
    bus.req = '0;
    check("busy_active", 32'(bus.busy), 1);
    wait_rsps(r0 + 1, 80);
    check("single_launch_count", 32'(launch_cyc_q.size() - l0), 1);
    stub_recv_word = 16'hFFFF;
    repeat (4) tick();
    check("rsp_data_hold", 32'(bus.rsp_data), 32'h3C5A);
    check("busy_idle", 32'(bus.busy), 0);
    check("cs_sel_idle", 32'(bus.cs_sel), 0);

    // Start timeout: stub never goes busy
    g0 = gnt_cyc_q.size(); r0 = rsp_cyc_q.size();
    stub_mode = 2;
    stub_recv_word = 16'h0BAD;
    exp_gnt_q.push_back('{4'b0100, 16'h2222});
    exp_rsp_q.push_back('{4'b0100, 16'h0BAD, 1'b1});
    bus.req = 4'b0100;
    wait_gnts(g0 + 1, 50);
    bus.req = '0;
    wait_rsps(r0 + 1, 50);
    if (rsp_cyc_q.size() > 0 && launch_cyc_q.size() > 0)
      check("timeout_latency", 32'(rsp_cyc_q[$] - launch_cyc_q[$]), 9);
    stub_mode = 0;
    busy_len = 2;
    stub_recv_word = 16'h600D;
    exp_gnt_q.push_back('{4'b0001, 16'h0000});
    exp_rsp_q.push_back('{4'b0001, 16'h600D, 1'b0});
    bus.req = 4'b0001;
    wait_gnts(g0 + 2, 50);
    bus.req = '0;
    wait_rsps(r0 + 2, 50);

    // Reset during WAIT_DONE: outputs clear at once, no response, ptr back to 0
    g0 = gnt_cyc_q.size(); l0 = launch_cyc_q.size();
    busy_len = 20;
    exp_gnt_q.push_back('{4'b1000, 16'h3333});
    bus.req = 4'b1000;
    wait_gnts(g0 + 1, 50);
    bus.req = '0;
    repeat (4) tick();
    check("pre_reset_busy", 32'(bus.busy), 1);
    saved_rsp = rsp_cyc_q.size();
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) tick();
    check("no_rsp_aborted", 32'(rsp_cyc_q.size()), 32'(saved_rsp));
    i_rst_n = 1'b1;
    g0 = gnt_cyc_q.size(); r0 = rsp_cyc_q.size();
    stub_recv_word = 16'h7E57;
    exp_gnt_q.push_back('{4'b0010, 16'hA5C3});
    exp_rsp_q.push_back('{4'b0010, 16'h7E57, 1'b0});
    bus.req = 4'b0110;
    wait_gnts(g0 + 1, 50);
    bus.req = '0;
    wait_rsps(r0 + 1, 80);

    // Loopback through the stub: three words from requester 0
    g0 = gnt_cyc_q.size(); r0 = rsp_cyc_q.size();
    stub_mode = 1;
    busy_len = 64;
    words = '{16'h1234, 16'hBEEF, 16'h0001};
    foreach (words[k]) begin
      exp_gnt_q.push_back('{4'b0001, words[k]});
      exp_rsp_q.push_back('{4'b0001, words[k], 1'b0});
    end
    for (int k = 0; k < 3; k++) begin
      bus.req_data[15:0] = words[k];
      bus.req = 4'b0001;
      wait_gnts(g0 + k + 1, 150);
    end
    bus.req = '0;
    wait_rsps(r0 + 3, 200);

    repeat (5) tick();
    check("exp_gnt_left", 32'(exp_gnt_q.size()), 0);
    check("exp_rsp_left", 32'(exp_rsp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter SPI_WORD_LEN, default 16, meaning word width, matching the shared SPI master.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning idle master_clock cycles between consecutive transactions (0..15).
REQ-004 The block SHALL have parameter START_TIMEOUT, default 8, meaning cycles allowed for the SPI master to report busy after launch (1..255).
REQ-005 The block SHALL have these ports, clock and reset first: master_clock in 1 system clock; i_rst_n in 1 asynchronous active-low reset.
REQ-006 The block SHALL have these requester ports: req in NUM_REQ per-requester level request; req_data in NUM_REQ*SPI_WORD_LEN word to send, requester i at slice [i*SPI_WORD_LEN +: SPI_WORD_LEN]; gnt out NUM_REQ one-hot one-cycle accept pulse.
REQ-007 The block SHALL have these response ports: rsp_valid out NUM_REQ one-hot one-cycle response pulse; rsp_data out SPI_WORD_LEN received word; rsp_err out 1 start-timeout flag, qualified by rsp_valid.
REQ-008 The block SHALL have these SPI-side ports: spi_process_next_word out 1 launch pulse; spi_data_word_send out SPI_WORD_LEN word to transmit; spi_processing_word in 1 master busy; spi_data_word_recv in SPI_WORD_LEN received word.
REQ-009 The block SHALL have these status ports: cs_sel out NUM_REQ one-hot active-high select of the owning requester; busy out 1, high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, LAUNCH, WAIT_START, WAIT_DONE, DONE and GAP, all registered on master_clock.
REQ-011 IDLE: when any req bit is high, the FSM SHALL grant the first requester at or after the rotating pointer ptr (wrapping NUM_REQ-1 -> 0), pulse gnt[i], latch req_data slice i into spi_data_word_send, set cs_sel[i], and go to LAUNCH.
REQ-012 After a grant to i, ptr SHALL become (i+1) mod NUM_REQ; a requester granted this round SHALL be lowest priority next round.
REQ-013 Grant SHALL be evaluated only in IDLE; req changes in any other state SHALL have no effect, and an unchanged req seen again in IDLE SHALL be a new request.
REQ-014 LAUNCH SHALL last exactly one cycle, with spi_process_next_word=1, then go to WAIT_START; spi_process_next_word SHALL be 0 in every other state.
REQ-015 WAIT_START SHALL go to WAIT_DONE on the first cycle spi_processing_word=1.
REQ-016 WAIT_START SHALL count cycles; if START_TIMEOUT cycles elapse without busy it SHALL go to DONE with the error flag set.
REQ-017 WAIT_DONE SHALL go to DONE on the first cycle spi_processing_word=0; there SHALL be no timeout in WAIT_DONE.
REQ-018 DONE SHALL last one cycle: rsp_valid[i]=1, rsp_data=spi_data_word_recv sampled in that cycle, and rsp_err=error flag.
REQ-019 rsp_data SHALL hold its value until the next DONE.
REQ-020 DONE SHALL clear cs_sel and the error flag, and go to GAP.
REQ-021 GAP SHALL stay GAP_CYCLES cycles, or pass straight to IDLE when GAP_CYCLES=0.
REQ-022 spi_data_word_send SHALL be stable from LAUNCH through DONE.
REQ-023 cs_sel SHALL be one-hot from LAUNCH through DONE and zero otherwise.
REQ-024 At most one gnt bit and at most one rsp_valid bit SHALL be high in any cycle.
REQ-025 Minimum grant-to-grant spacing SHALL be 5+GAP_CYCLES cycles.
REQ-026 Counters SHALL be sized to their parameter maxima and SHALL NOT wrap.

Reset
REQ-027 While i_rst_n=0, regardless of state, the block SHALL hold: state=IDLE, ptr=0, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, spi_process_next_word=0, spi_data_word_send=0, cs_sel=0, busy=0, and all counters=0.
REQ-028 A reset asserted mid-transaction SHALL produce no rsp_valid for the aborted transaction.
REQ-029 The first grant after reset release SHALL follow REQ-011 with ptr=0.

Verification
REQ-030 Single request: req=4'b0010, req_data[31:16]=16'hA5C3, stub busy 20 cycles -> gnt=4'b0010, one process_next_word pulse, send=16'hA5C3, rsp_valid=4'b0010 with recv value, rsp_err=0.
REQ-031 Contention: req=4'b1111 held -> grant order 0,1,2,3,0 and each pair of grants ≥7 cycles apart with GAP_CYCLES=2.
REQ-032 Pointer wrap: after a grant to 3, req=4'b1001 -> next grant is 0, not 3.
REQ-033 Start timeout: spi_processing_word held 0 -> rsp_valid exactly 9 cycles after LAUNCH (LAUNCH + 8-cycle timeout), rsp_err=1, and the next grant proceeds normally.
REQ-034 Reset in WAIT_DONE: i_rst_n low 3 cycles -> all outputs zero immediately, no rsp_valid, first grant after release goes to the lowest active index.
REQ-035 Integration with the SPI master (CPOL=0, CPHA=0, SCLK_DIV=4) in loopback: 3 queued words 16'h1234, 16'hBEEF, 16'h0001 -> each rsp_data equals the sent word.
